// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if
//   Bundles the push stream, pop stream, status outputs and SRAM port
//   signals of the FIFO controller.
//   master : the controller's view. It receives push_valid/push_data,
//            pop_ready and ram_read_data. It drives everything else.
//   slave  : the environment's view, which is the producer, consumer and RAM.
// Signals
//   push_valid/push_ready/push_data : enqueue handshake
//   pop_valid/pop_ready/pop_data    : dequeue handshake (registered head word)
//   level, full, empty              : occupancy status
//   ram_wr_en/ram_write_addr/ram_write_data : RAM write port
//   ram_rd_en/ram_read_addr/ram_read_data   : RAM read port (async read data)
interface sram_fifo_ctrl_if #(
  parameter int datawidth = 8,
  parameter int addrwidth = 8
);
  logic                 push_valid;
  logic                 push_ready;
  logic [datawidth-1:0] push_data;
  logic                 pop_valid;
  logic                 pop_ready;
  logic [datawidth-1:0] pop_data;
  logic [addrwidth:0]   level;
  logic                 full;
  logic                 empty;
  logic                 ram_wr_en;
  logic [addrwidth-1:0] ram_write_addr;
  logic [datawidth-1:0] ram_write_data;
  logic                 ram_rd_en;
  logic [addrwidth-1:0] ram_read_addr;
  logic [datawidth-1:0] ram_read_data;

  modport master (
    input  push_valid, push_data, pop_ready, ram_read_data,
    output push_ready, pop_valid, pop_data, level, full, empty,
           ram_wr_en, ram_write_addr, ram_write_data,
           ram_rd_en, ram_read_addr
  );

  modport slave (
    output push_valid, push_data, pop_ready, ram_read_data,
    input  push_ready, pop_valid, pop_data, level, full, empty,
           ram_wr_en, ram_write_addr, ram_write_data,
           ram_rd_en, ram_read_addr
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
//   FIFO controller placed in front of a dual-port SRAM. The SRAM has a
//   synchronous write and an asynchronous read. The controller turns a
//   valid/ready push stream and a valid/ready pop stream into RAM
//   write/read traffic. The head word is held in a one-entry registered
//   output stage. Capacity is 2**addrwidth RAM words plus the output stage.
// Ports
//   wr_clk : single clock for all logic
//   reset  : synchronous, active-high
//   bus    : sram_fifo_ctrl_if.master. It carries the push/pop handshakes,
//            level/full/empty and the RAM port signals.
module sram_fifo_ctrl #(
  parameter int datawidth = 8,
  parameter int addrwidth = 8
) (
  input logic                wr_clk,
  input logic                reset,
  sram_fifo_ctrl_if.master   bus
);
  localparam int PW = addrwidth + 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 pop_valid_q, pop_valid_d;
  logic [datawidth-1:0] pop_data_q, pop_data_d;

  logic [PW-1:0] ram_cnt;
  logic          ram_full;
  logic          ram_empty;
  logic          push_fire;
  logic          pop_fire;
  logic          load;

  // Occupancy and flags come only from registered pointers. Level therefore
  // has no combinational path from push_valid or pop_ready.
  always_comb begin
    ram_cnt   = wr_ptr_q - rd_ptr_q;
    ram_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    ram_empty = (wr_ptr_q == rd_ptr_q);
  end

  // Push is blocked during reset so that the RAM is not written in the reset cycle.
  // The output stage refills whenever it is empty or is being drained.
  always_comb begin
    push_fire = bus.push_valid && !ram_full && !reset;
    pop_fire  = pop_valid_q && bus.pop_ready;
    load      = !ram_empty && (!pop_valid_q || bus.pop_ready);
  end

  always_comb begin
    bus.push_ready     = !ram_full && !reset;
    bus.ram_wr_en      = push_fire;
    bus.ram_write_addr = wr_ptr_q[PW-2:0];
    bus.ram_write_data = bus.push_data;
    bus.ram_rd_en      = load;
    bus.ram_read_addr  = rd_ptr_q[PW-2:0];
    bus.pop_valid      = pop_valid_q;
    bus.pop_data       = pop_data_q;
    bus.level          = ram_cnt + {{(PW-1){1'b0}}, pop_valid_q};
    bus.full           = ram_full;
    bus.empty          = ram_empty && !pop_valid_q;
  end

  // A load takes priority over a pop. A load is the refill that happens
  // when a pop and a load occur in the same cycle, which gives one word
  // per cycle when streaming. A pop with no load empties the stage.
  // pop_data keeps its old value in that case.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pop_valid_d = pop_valid_q;
    pop_data_d  = pop_data_q;
    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (load) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      pop_valid_d = 1'b1;
      pop_data_d  = bus.ram_read_data;
    end else if (pop_fire) begin
      pop_valid_d = 1'b0;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end
endmodule
